flash_stream_io: RTL and testbench

CPU-bus register interface to the SPI flash controller, successor to the single-byte flash port: a background prefetch engine streams consecutive flash bytes into a parametrised FIFO, so the CPU drains data at one byte per bus access without polling. It also provides a programmable transfer length and a sticky underflow flag. It sits in the I/O decode at 0xDE00–0xDE0F, between the CPU bus and the existing SPI flash controller.

---
 rtl/flash_stream_io.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_flash_stream_io.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_stream_io.sv
// ============================================================================
// flash_stream_io
// ----------------------------------------------------------------------------
// CPU-bus register window onto the SPI flash controller. A background prefetch
// engine streams consecutive flash bytes into a small FIFO, so the CPU drains
// data at one byte per bus access without polling. Also provides a
// programmable transfer length and a sticky underflow flag.
//
// Optional feature macro: FLASH_STREAM_IRQ_EN
//   defined   -> adds output irq and register 10 IRQ_THR (level threshold)
//   undefined -> no irq port, register 10 and STATUS bit7 read 0
//
// Parameters
//   ADDR_W      flash address width (24 or 32)
//   FIFO_DEPTH  prefetch FIFO entries (power of two, 2..64)
//
// Ports
//   clk                system clock
//   reset              synchronous, active-high reset
//   bus_access_strobe  one-cycle CPU bus access enable
//   a[15:0]            address bus, a[3:0] selects the register
//   select             module select
//   r_w_n              1 = read, 0 = write
//   d_in[7:0]          CPU write data
//   d_out[7:0]         registered CPU read data (holds until next read)
//   flash_d_ready      controller data valid
//   flash_d_out[7:0]   controller data
//   flash_addr         fetch address presented to the controller
//   flash_req_r_addr   one-cycle pulse: random read at flash_addr
//   flash_req_r_next   one-cycle pulse: read next sequential byte
//   irq                (FLASH_STREAM_IRQ_EN only) level interrupt
//
// Register map (a[3:0])
//   0 STATUS  R   {irq_pending,3'b0,busy,underflow,full,not_empty}
//   1..4 ADDR R/W base address bytes, little-endian
//   5 DATA    R   pops the FIFO (0x00 + underflow when empty)
//   6 LEVEL   R   FIFO fill count
//   7 CTRL    W   bit0 start, bit1 stop, bit2 clr_underflow, bit3 clr_irq
//   8/9 LEN   R/W bytes to fetch, 0 = unlimited
//   10 IRQ_THR R/W (FLASH_STREAM_IRQ_EN only)
// ============================================================================
module flash_stream_io #(
    parameter int ADDR_W     = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_access_strobe,
    input  logic [15:0]       a,
    input  logic              select,
    input  logic              r_w_n,
    input  logic [7:0]        d_in,
    output logic [7:0]        d_out,
    input  logic              flash_d_ready,
    input  logic [7:0]        flash_d_out,
    output logic [ADDR_W-1:0] flash_addr,
    output logic              flash_req_r_addr,
    output logic              flash_req_r_next
`ifdef FLASH_STREAM_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ_ADDR = 3'd1;
    localparam logic [2:0] S_REQ_NEXT = 3'd2;
    localparam logic [2:0] S_GUARD    = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_PAUSE    = 3'd5;

    localparam logic [3:0] R_STATUS  = 4'd0;
    localparam logic [3:0] R_ADDR0   = 4'd1;
    localparam logic [3:0] R_ADDR1   = 4'd2;
    localparam logic [3:0] R_ADDR2   = 4'd3;
    localparam logic [3:0] R_ADDR3   = 4'd4;
    localparam logic [3:0] R_DATA    = 4'd5;
    localparam logic [3:0] R_LEVEL   = 4'd6;
    localparam logic [3:0] R_CTRL    = 4'd7;
    localparam logic [3:0] R_LEN_LO  = 4'd8;
    localparam logic [3:0] R_LEN_HI  = 4'd9;
    localparam logic [3:0] R_IRQ_THR = 4'd10;

    // Byte lane of the 32-bit address shadow; bytes beyond ADDR_W are held
    // at zero by the write path, so they naturally read back as 0.
    function automatic logic [7:0] addr_byte(input logic [31:0] v,
                                             input logic [1:0]  idx);
        return v[idx*8 +: 8];
    endfunction

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       access;
    logic       rd_en;
    logic       wr_en;
    logic [3:0] reg_sel;
    logic       ctrl_wr;
    logic       do_flush;
    logic       do_start;
    logic       unused_addr_bits;

    assign access   = bus_access_strobe & select;
    assign rd_en    = access & r_w_n;
    assign wr_en    = access & ~r_w_n;
    assign reg_sel  = a[3:0];
    assign ctrl_wr  = wr_en && (reg_sel == R_CTRL);
    // Stop wins over start; either one flushes the FIFO.
    assign do_flush = ctrl_wr && (d_in[0] || d_in[1]);
    assign do_start = ctrl_wr && d_in[0] && !d_in[1];
    assign unused_addr_bits = ^a[15:4];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]        state;
    logic [ADDR_W-1:0] fetch_addr;
    logic [15:0]       remaining;
    logic              limited;
    logic [31:0]       addr_shadow;
    logic [15:0]       len_reg;
    logic              underflow;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after;

    logic              not_empty;
    logic              full;
    logic              busy;
    logic              push;
    logic              pop;
    logic [7:0]        rd_data;
    logic              irq_flag;
    logic [7:0]        irq_thr_rd;

    assign not_empty = (count != '0);
    assign full      = (count == FULL_CNT);
    assign busy      = (state != S_IDLE);

    // Data arriving during GUARD, or on the cycle a start/stop flushes the
    // FIFO, belongs to an abandoned request and is dropped.
    assign push = (state == S_WAIT) && flash_d_ready && !do_flush && !full;
    // Only a stored entry can be popped, so a byte being pushed this cycle
    // is never the one read out.
    assign pop  = rd_en && (reg_sel == R_DATA) && not_empty;

    assign count_after = count + CNT_W'(push) - CNT_W'(pop);

    assign flash_addr       = fetch_addr;
    assign flash_req_r_addr = (state == S_REQ_ADDR);
    assign flash_req_r_next = (state == S_REQ_NEXT);

    // ------------------------------------------------------------------
    // Optional level interrupt
    // ------------------------------------------------------------------
`ifdef FLASH_STREAM_IRQ_EN
    logic [7:0] irq_thr;
    logic       irq_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_thr     <= 8'h00;
            irq_pending <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == R_IRQ_THR)) begin
                irq_thr <= d_in;
            end
            if (ctrl_wr && d_in[3]) begin
                irq_pending <= 1'b0;
            end else if ((irq_thr != 8'h00) && (8'(count) >= irq_thr)) begin
                irq_pending <= 1'b1;
            end
        end
    end

    assign irq        = irq_pending;
    assign irq_flag   = irq_pending;
    assign irq_thr_rd = irq_thr;
`else
    assign irq_flag   = 1'b0;
    assign irq_thr_rd = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Register read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        case (reg_sel)
            R_STATUS:  rd_data = {irq_flag, 3'b000, busy, underflow, full, not_empty};
            R_ADDR0:   rd_data = addr_byte(addr_shadow, 2'd0);
            R_ADDR1:   rd_data = addr_byte(addr_shadow, 2'd1);
            R_ADDR2:   rd_data = addr_byte(addr_shadow, 2'd2);
            R_ADDR3:   rd_data = addr_byte(addr_shadow, 2'd3);
            R_DATA:    if (not_empty) rd_data = mem[rd_ptr];
            R_LEVEL:   rd_data = 8'(count);
            R_LEN_LO:  rd_data = len_reg[7:0];
            R_LEN_HI:  rd_data = len_reg[15:8];
            R_IRQ_THR: rd_data = irq_thr_rd;
            default:   rd_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus-side registers: read data, shadows, underflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            d_out       <= 8'h00;
            addr_shadow <= 32'h0;
            len_reg     <= 16'h0;
            underflow   <= 1'b0;
        end else begin
            if (rd_en) begin
                d_out <= rd_data;
            end
            if (wr_en) begin
                for (int i = 0; i < 4; i++) begin
                    if ((reg_sel == 4'(i + 1)) && (i < ADDR_W / 8)) begin
                        addr_shadow[i*8 +: 8] <= d_in;
                    end
                end
                if (reg_sel == R_LEN_LO) len_reg[7:0]  <= d_in;
                if (reg_sel == R_LEN_HI) len_reg[15:8] <= d_in;
            end
            if (rd_en && (reg_sel == R_DATA) && !not_empty) begin
                underflow <= 1'b1;
            end else if (ctrl_wr && d_in[2]) begin
                underflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            fetch_addr <= '0;
            remaining  <= 16'h0;
            limited    <= 1'b0;
        end else if (do_flush) begin
            // A start while busy simply restarts; any ready for the old
            // request lands in the GUARD cycle and is ignored.
            if (do_start) begin
                state      <= S_REQ_ADDR;
                fetch_addr <= addr_shadow[ADDR_W-1:0];
                remaining  <= len_reg;
                limited    <= (len_reg != 16'h0);
            end else begin
                state <= S_IDLE;
            end
        end else begin
            case (state)
                S_IDLE: state <= S_IDLE;
                S_REQ_ADDR, S_REQ_NEXT: state <= S_GUARD;
                S_GUARD: state <= S_WAIT;
                S_WAIT: begin
                    if (push) begin
                        fetch_addr <= fetch_addr + ADDR_W'(1);
                        if (limited) begin
                            remaining <= remaining - 16'd1;
                        end
                        if (limited && (remaining == 16'd1)) begin
                            state <= S_IDLE;
                        end else if (count_after == FULL_CNT) begin
                            state <= S_PAUSE;
                        end else begin
                            state <= S_REQ_NEXT;
                        end
                    end
                end
                S_PAUSE: if (!full) state <= S_REQ_NEXT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_after;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= flash_d_out;
        end
    end

endmodule

// File: tb/tb_flash_stream_io.sv
// ============================================================================
// tb_flash_stream_io
// ----------------------------------------------------------------------------
// Directed bench for flash_stream_io. A small flash controller model answers
// each request after LAT cycles with data derived from the requested address
// (addr[7:0] + 0x5B). Expected bytes go into a scoreboard queue when a
// transfer is started and are popped as DATA reads return.
// ============================================================================
`timescale 1ns/1ps
module tb_flash_stream_io;

    localparam int ADDR_W     = 24;
    localparam int FIFO_DEPTH = 8;
    localparam int LAT        = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              bus_access_strobe = 1'b0;
    logic [15:0]       a = 16'h0;
    logic              select = 1'b0;
    logic              r_w_n = 1'b1;
    logic [7:0]        d_in = 8'h00;
    logic [7:0]        d_out;
    logic              flash_d_ready;
    logic [7:0]        flash_d_out;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_req_r_addr;
    logic              flash_req_r_next;
`ifdef FLASH_STREAM_IRQ_EN
    logic              irq;
`endif

    always #5 clk = ~clk;

    flash_stream_io #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus_access_strobe (bus_access_strobe),
        .a                 (a),
        .select            (select),
        .r_w_n             (r_w_n),
        .d_in              (d_in),
        .d_out             (d_out),
        .flash_d_ready     (flash_d_ready),
        .flash_d_out       (flash_d_out),
        .flash_addr        (flash_addr),
        .flash_req_r_addr  (flash_req_r_addr),
        .flash_req_r_next  (flash_req_r_next)
`ifdef FLASH_STREAM_IRQ_EN
        ,
        .irq               (irq)
`endif
    );

    // ---------------- flash controller model ----------------
    logic              model_en = 1'b1;
    logic              model_ready = 1'b0;
    logic [7:0]        model_data = 8'h00;
    int                dly = 0;
    logic              manual_ready = 1'b0;
    logic [7:0]        manual_data = 8'h00;
    int                n_raddr = 0;
    int                n_rnext = 0;
    int                n_pulse_err = 0;
    logic              prev_req = 1'b0;
    logic [ADDR_W-1:0] last_raddr = '0;

    function automatic logic [7:0] fdata(input logic [ADDR_W-1:0] ad);
        return ad[7:0] + 8'h5B;
    endfunction

    always @(posedge clk) begin
        model_ready <= 1'b0;
        if (flash_req_r_addr) begin
            n_raddr    <= n_raddr + 1;
            last_raddr <= flash_addr;
        end
        if (flash_req_r_next) n_rnext <= n_rnext + 1;
        if ((flash_req_r_addr || flash_req_r_next) &&
            (prev_req || (flash_req_r_addr && flash_req_r_next)))
            n_pulse_err <= n_pulse_err + 1;
        prev_req <= flash_req_r_addr | flash_req_r_next;
        if (model_en && (flash_req_r_addr || flash_req_r_next)) begin
            dly        <= LAT;
            model_data <= fdata(flash_addr);
        end else if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) model_ready <= 1'b1;
        end
    end

    assign flash_d_ready = model_ready | manual_ready;
    assign flash_d_out   = manual_ready ? manual_data : model_data;

    // ---------------- checking / bus helpers ----------------
    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] ad, input logic [7:0] dt);
        @(negedge clk);
        bus_access_strobe = 1'b1; select = 1'b1; r_w_n = 1'b0;
        a = {12'h000, ad}; d_in = dt;
        @(negedge clk);
        bus_access_strobe = 1'b0; select = 1'b0; r_w_n = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] ad, output logic [7:0] dt);
        @(negedge clk);
        bus_access_strobe = 1'b1; select = 1'b1; r_w_n = 1'b1;
        a = {12'h000, ad};
        @(negedge clk);
        bus_access_strobe = 1'b0; select = 1'b0;
        dt = d_out;
    endtask

    task automatic read_reg_check(input string tag, input logic [3:0] ad, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(ad, v);
        check(tag, 32'(v), 32'(exp));
    endtask

    task automatic sb_push_run(input logic [ADDR_W-1:0] base, input int n);
        for (int k = 0; k < n; k++) sb.push_back(fdata(base + ADDR_W'(k)));
    endtask

    task automatic read_data_check(input string tag);
        logic [7:0]  v;
        logic [31:0] exp;
        bus_read(4'd5, v);
        exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hDEAD_BEEF;
        check(tag, 32'(v), exp);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic [7:0] s = 8'hFF;
        for (int i = 0; i < budget; i++) begin
            bus_read(4'd0, s);
            if (!s[3]) break;
        end
        check(tag, 32'(s[3]), 32'd0);
    endtask

    task automatic wait_level(input string tag, input int lvl, input int budget);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < budget; i++) begin
            bus_read(4'd6, v);
            if (int'(v) == lvl) break;
        end
        check(tag, 32'(v), 32'(lvl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int ra0;
        int rn0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_d_out", 32'(d_out), 32'h0);
        check("rst_flash_addr", 32'(flash_addr), 32'h0);
        check("rst_reqs", {30'b0, flash_req_r_addr, flash_req_r_next}, 32'h0);
        reset = 1'b0;
        for (int r = 0; r < 16; r++)
            read_reg_check($sformatf("reg%0d_after_reset", r), 4'(r), 8'h00);
        bus_write(4'd7, 8'h04);
        repeat (20) @(negedge clk);
        check("idle_raddr_count", 32'(n_raddr), 32'd0);
        check("idle_rnext_count", 32'(n_rnext), 32'd0);

        // Bounded transfer of 4 bytes from 0x012345
        bus_write(4'd1, 8'h45);
        bus_write(4'd2, 8'h23);
        bus_write(4'd3, 8'h01);
        bus_write(4'd8, 8'h04);
        bus_write(4'd9, 8'h00);
        read_reg_check("addr0_rb", 4'd1, 8'h45);
        read_reg_check("addr3_rb_zero", 4'd4, 8'h00);
        check("no_req_on_shadow_write", 32'(n_raddr), 32'd0);
        sb_push_run(24'h012345, 4);
        ra0 = n_raddr; rn0 = n_rnext;
        bus_write(4'd7, 8'h01);
        wait_idle("len4_busy_clears", 100);
        check("len4_raddr_count", 32'(n_raddr - ra0), 32'd1);
        check("len4_rnext_count", 32'(n_rnext - rn0), 32'd3);
        read_reg_check("len4_level", 4'd6, 8'd4);
        check("len4_flash_addr", 32'(flash_addr), 32'h012349);
        for (int k = 0; k < 4; k++) read_data_check($sformatf("len4_data%0d", k));
        read_reg_check("len4_status_drained", 4'd0, 8'h00);

        // Unlimited transfer fills FIFO and pauses
        bus_write(4'd8, 8'h00);
        sb_push_run(24'h012345, 1);
        bus_write(4'd7, 8'h01);
        wait_level("fill_level8", FIFO_DEPTH, 100);
        read_reg_check("fill_status_full_busy", 4'd0, 8'h0B);
        rn0 = n_rnext;
        repeat (12) @(negedge clk);
        check("pause_no_requests", 32'(n_rnext - rn0), 32'd0);
        read_data_check("pause_pop_data");
        wait_level("refill_level8", FIFO_DEPTH, 40);
        repeat (6) @(negedge clk);
        check("pause_one_rnext", 32'(n_rnext - rn0), 32'd1);
        bus_write(4'd7, 8'h03);
        read_reg_check("stop_status", 4'd0, 8'h00);
        read_reg_check("stop_level", 4'd6, 8'h00);

        // Underflow
        read_reg_check("underflow_data", 4'd5, 8'h00);
        read_reg_check("underflow_status", 4'd0, 8'h04);
        bus_write(4'd7, 8'h04);
        read_reg_check("underflow_cleared", 4'd0, 8'h00);

        // Address wrap
        bus_write(4'd1, 8'hFF);
        bus_write(4'd2, 8'hFF);
        bus_write(4'd3, 8'hFF);
        bus_write(4'd8, 8'h02);
        sb_push_run(24'hFFFFFF, 2);
        ra0 = n_raddr; rn0 = n_rnext;
        bus_write(4'd7, 8'h01);
        wait_idle("wrap_busy_clears", 100);
        check("wrap_flash_addr", 32'(flash_addr), 32'h000001);
        check("wrap_rnext_count", 32'(n_rnext - rn0), 32'd1);
        read_reg_check("wrap_level", 4'd6, 8'd2);
        read_data_check("wrap_data0");
        read_data_check("wrap_data1");

        // Start during WAIT, stale ready in GUARD
        model_en = 1'b0;
        bus_write(4'd1, 8'h10);
        bus_write(4'd2, 8'h00);
        bus_write(4'd3, 8'h00);
        bus_write(4'd8, 8'h00);
        bus_write(4'd7, 8'h01);
        repeat (6) @(negedge clk);
        read_reg_check("stuck_in_wait_status", 4'd0, 8'h08);
        bus_write(4'd1, 8'h80);
        sb_push_run(24'h000080, 2);
        model_en = 1'b1;
        ra0 = n_raddr;
        bus_write(4'd7, 8'h01);
        @(negedge clk);
        manual_ready = 1'b1; manual_data = 8'hEE;
        @(negedge clk);
        manual_ready = 1'b0;
        check("abort_raddr_count", 32'(n_raddr - ra0), 32'd1);
        check("abort_raddr_addr", 32'(last_raddr), 32'h000080);
        wait_level("abort_fill", FIFO_DEPTH, 100);
        read_data_check("abort_data0");
        read_data_check("abort_data1");
        bus_write(4'd7, 8'h02);

        // Reset in the middle of a fetch; the late ready must be ignored
        bus_write(4'd1, 8'h40);
        bus_write(4'd7, 8'h01);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_reqs", {30'b0, flash_req_r_addr, flash_req_r_next}, 32'h0);
        check("midrst_flash_addr", 32'(flash_addr), 32'h0);
        read_reg_check("midrst_status", 4'd0, 8'h00);
        read_reg_check("midrst_level", 4'd6, 8'h00);
        read_reg_check("midrst_addr0", 4'd1, 8'h00);

        check("req_pulse_shape", 32'(n_pulse_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
